tx_scheduler: RTL and testbench

Arbitrating front-end for the burst-encoded `tx` transmitter. Accepts WIDTH-bit frames from N_REQ independent requesters over a valid/ready handshake and picks one round-robin. It launches the winner into `tx` with a one-cycle `valid_in` pulse and waits out the transmission via `tx`'s `busy`. It then enforces a minimum silent gap before the next frame, and flags any launch that `tx` fails to acknowledge.

---
 rtl/tx_scheduler.sv | 116 +++++++++++
 tb/tb_tx_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/tx_scheduler.sv
// Round-robin front-end for the tx transmitter: accepts one frame, launches it,
// waits out the transmission, then holds a silent gap before the next launch.
module tx_scheduler #(
   parameter int WIDTH    = 128,
   parameter int N_REQ    = 2,
   parameter int GAP      = 1000,
   parameter int START_TO = 16,
   localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic [N_REQ-1:0]       req_valid_in,
   input  logic [N_REQ*WIDTH-1:0] req_data_in,
   output logic [N_REQ-1:0]       req_ready_out,
   output logic                   tx_valid_out,
   output logic [WIDTH-1:0]       tx_data_out,
   input  logic                   tx_busy_in,
   output logic [GW-1:0]          grant_out,
   output logic                   err_out,
   output logic [15:0]            frame_count_out
);

   localparam int TMAX = (GAP > START_TO) ? GAP : START_TO;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(START_TO - 1);
   localparam logic [TW-1:0] GAP_LAST = TW'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT_START, ST_WAIT_DONE, ST_GAP} state_t;

   state_t                       state, nxt_state;
   logic [GW-1:0]                rr_ptr, win, nxt_ptr;
   logic [TW-1:0]                timer;
   logic [15:0]                  frame_cnt;
   logic                         found, accept, to_hit;
   logic [N_REQ-1:0][WIDTH-1:0]  frames;

   assign frames = req_data_in;

   // First valid requester at or after rr_ptr, searching upward with wrap.
   always_comb begin
      int idx;
      idx   = 0;
      win   = '0;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req_valid_in[idx]) begin
            found = 1'b1;
            win   = GW'(idx);
         end
      end
   end

   assign nxt_ptr       = (win == GW'(N_REQ - 1)) ? '0 : win + GW'(1);
   assign accept        = rst_in && (state == ST_IDLE) && !tx_busy_in && found;
   assign req_ready_out = accept ? (N_REQ'(1) << win) : '0;
   assign to_hit        = (timer == TO_LAST);
   assign frame_count_out = frame_cnt;

   always_ff @(posedge clk_in) begin
      if (!rst_in) state <= ST_IDLE;
      else         state <= nxt_state;
   end

   // With GAP==0 the gap state is bypassed so a new frame can be accepted
   // the cycle right after busy falls.
   always_comb begin
      nxt_state = state;
      case (state)
         ST_IDLE:       if (accept) nxt_state = ST_WAIT_START;
         ST_WAIT_START: begin
            if (tx_busy_in)  nxt_state = ST_WAIT_DONE;
            else if (to_hit) nxt_state = (GAP == 0) ? ST_IDLE : ST_GAP;
         end
         ST_WAIT_DONE:  if (!tx_busy_in) nxt_state = (GAP == 0) ? ST_IDLE : ST_GAP;
         ST_GAP:        if (timer == GAP_LAST) nxt_state = ST_IDLE;
         default:       nxt_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         rr_ptr       <= '0;
         timer        <= '0;
         tx_valid_out <= 1'b0;
         tx_data_out  <= '0;
         grant_out    <= '0;
         err_out      <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         tx_valid_out <= accept;
         err_out      <= 1'b0;
         case (state)
            ST_IDLE: if (accept) begin
               tx_data_out <= frames[win];
               grant_out   <= win;
               rr_ptr      <= nxt_ptr;
               timer       <= '0;
            end
            ST_WAIT_START: begin
               // busy on the expiring cycle still counts as a start
               if (tx_busy_in) frame_cnt <= frame_cnt + 16'd1;
               else if (to_hit) begin
                  err_out <= 1'b1;
                  timer   <= '0;
               end else timer <= timer + TW'(1);
            end
            ST_WAIT_DONE: timer <= '0;
            ST_GAP:       timer <= timer + TW'(1);
            default:      timer <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_scheduler.sv
// Directed bench for tx_scheduler: a GAP=1000 instance for arbitration, timeout
// and reset, and a GAP=0 instance for short gap and counter wrap.
module tb_tx_scheduler;

   localparam int W = 128;
   localparam logic [W-1:0] ONES = {W{1'b1}};
   localparam logic [W-1:0] PAT_A = {(W/4){4'hA}};
   localparam logic [W-1:0] PAT_5 = {(W/4){4'h5}};
   localparam logic [W-1:0] PAT_Z = {(W/16){16'h1234}};

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0]        valid_w, valid_z, rdy_w, rdy_z;
   logic [1:0][W-1:0] data_w, data_z;
   logic              busy_w, busy_z, txv_w, txv_z, err_w, err_z;
   logic [W-1:0]      txd_w, txd_z;
   logic [0:0]        gnt_w, gnt_z;
   logic [15:0]       cnt_w, cnt_z;

   tx_scheduler #(.WIDTH(W), .N_REQ(2), .GAP(1000), .START_TO(16)) dut_w (
      .clk_in(clk), .rst_in(rst), .req_valid_in(valid_w), .req_data_in(data_w),
      .req_ready_out(rdy_w), .tx_valid_out(txv_w), .tx_data_out(txd_w),
      .tx_busy_in(busy_w), .grant_out(gnt_w), .err_out(err_w),
      .frame_count_out(cnt_w));

   tx_scheduler #(.WIDTH(W), .N_REQ(2), .GAP(0), .START_TO(16)) dut_z (
      .clk_in(clk), .rst_in(rst), .req_valid_in(valid_z), .req_data_in(data_z),
      .req_ready_out(rdy_z), .tx_valid_out(txv_z), .tx_data_out(txd_z),
      .tx_busy_in(busy_z), .grant_out(gnt_z), .err_out(err_z),
      .frame_count_out(cnt_z));

   bit          use_z = 1'b0;
   logic [1:0]  rdy_m;
   logic        txv_m;
   logic [W-1:0] txd_m;
   logic [0:0]  gnt_m;
   logic [15:0] cnt_m;

   always_comb begin
      if (use_z) begin
         rdy_m = rdy_z; txv_m = txv_z; txd_m = txd_z; gnt_m = gnt_z; cnt_m = cnt_z;
      end else begin
         rdy_m = rdy_w; txv_m = txv_w; txd_m = txd_w; gnt_m = gnt_w; cnt_m = cnt_w;
      end
   end

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic set_busy(input logic v);
      if (use_z) busy_z = v; else busy_w = v;
   endtask

   task automatic clr_valid(input int g);
      if (use_z) valid_z[g] = 1'b0; else valid_w[g] = 1'b0;
   endtask

   // Entered #1 after a negedge. Waits for ready, launches, runs a short
   // busy burst and returns #1 after the negedge at which busy fell.
   task automatic frame(input string tag, input int g, input logic [W-1:0] d,
                        input int exp_wait, input logic [15:0] exp_cnt, input bit drop);
      int n;
      n = 0;
      while (rdy_m == 2'b00 && n < 3000) begin
         @(negedge clk); #1; n++;
      end
      if (exp_wait >= 0) chk({tag, "_wait"}, W'(n), W'(exp_wait));
      chk({tag, "_rdy"}, W'(rdy_m), W'(2'b01 << g));
      @(negedge clk);
      if (drop) clr_valid(g);
      #1;
      chk({tag, "_txv"}, W'(txv_m), W'(1));
      chk({tag, "_data"}, txd_m, d);
      chk({tag, "_gnt"}, W'(gnt_m), W'(g));
      chk({tag, "_rdy_off"}, W'(rdy_m), W'(0));
      set_busy(1'b1);
      @(negedge clk); #1;
      chk({tag, "_txv_off"}, W'(txv_m), W'(0));
      chk({tag, "_cnt"}, W'(cnt_m), W'(exp_cnt));
      repeat (3) @(negedge clk);
      set_busy(1'b0);
      #1;
   endtask

   initial begin
      int n;
      rst = 1'b0;
      busy_w = 1'b0; busy_z = 1'b0;
      valid_w = '0; valid_z = '0;
      data_w = '0; data_z = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rdy", W'(rdy_w), W'(0));
      chk("rst_txv", W'(txv_w), W'(0));
      chk("rst_data", txd_w, W'(0));
      chk("rst_gnt", W'(gnt_w), W'(0));
      chk("rst_err", W'(err_w), W'(0));
      chk("rst_cnt", W'(cnt_w), W'(0));

      // single requester, full GAP measured from busy fall
      @(negedge clk);
      rst = 1'b1;
      valid_w = 2'b01; data_w[0] = ONES;
      #1;
      frame("t1", 0, ONES, 0, 16'd1, 1'b1);
      data_w[0] = PAT_A; data_w[1] = PAT_5; valid_w = 2'b11;
      @(negedge clk); #1;
      chk("t1_hold", txd_w, ONES);

      // both valid: rr_ptr is 1 after the first grant, so 1,0,1,0
      frame("rr1", 1, PAT_5, 1000, 16'd2, 1'b0);
      frame("rr2", 0, PAT_A, 1001, 16'd3, 1'b0);
      frame("rr3", 1, PAT_5, 1001, 16'd4, 1'b0);
      frame("rr4", 0, PAT_A, 1001, 16'd5, 1'b0);
      valid_w = 2'b01;

      // start timeout: busy never rises
      n = 0;
      while (rdy_w == 2'b00 && n < 3000) begin @(negedge clk); #1; n++; end
      chk("to_wait", W'(n), W'(1001));
      @(negedge clk); valid_w = 2'b00; #1;
      chk("to_txv", W'(txv_w), W'(1));
      n = 0;
      while (!err_w && n < 100) begin @(negedge clk); #1; n++; end
      chk("to_lat", W'(n), W'(16));
      chk("to_cnt", W'(cnt_w), W'(5));
      valid_w = 2'b01;
      @(negedge clk); #1;
      chk("to_pulse", W'(err_w), W'(0));
      n = 1;
      while (rdy_w == 2'b00 && n < 3000) begin @(negedge clk); #1; n++; end
      chk("to_gap", W'(n), W'(1000));

      // busy rising exactly at expiry counts as a start
      @(negedge clk); valid_w = 2'b00; #1;
      chk("edge_txv", W'(txv_w), W'(1));
      repeat (15) @(negedge clk);
      busy_w = 1'b1;
      @(negedge clk); #1;
      chk("edge_err", W'(err_w), W'(0));
      chk("edge_cnt", W'(cnt_w), W'(6));
      repeat (2) @(negedge clk);
      busy_w = 1'b0; valid_w = 2'b01;
      #1;

      // reset during WAIT_DONE with busy high
      n = 0;
      while (rdy_w == 2'b00 && n < 3000) begin @(negedge clk); #1; n++; end
      chk("rs_wait", W'(n), W'(1001));
      @(negedge clk); valid_w = 2'b00; busy_w = 1'b1;
      @(negedge clk); #1;
      chk("rs_cnt", W'(cnt_w), W'(7));
      rst = 1'b0;
      @(negedge clk); rst = 1'b1; #1;
      chk("rs_txv", W'(txv_w), W'(0));
      chk("rs_data", txd_w, W'(0));
      chk("rs_gnt", W'(gnt_w), W'(0));
      chk("rs_err", W'(err_w), W'(0));
      chk("rs_cnt0", W'(cnt_w), W'(0));
      valid_w = 2'b11;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk("rs_busy_rdy", W'(rdy_w), W'(0));
      end
      @(negedge clk); busy_w = 1'b0; #1;
      chk("rs_rr", W'(rdy_w), W'(2'b01));
      frame("rs_f", 0, PAT_A, 0, 16'd1, 1'b1);
      valid_w = 2'b00;

      // GAP=0 instance: ready one cycle after busy falls
      use_z = 1'b1;
      data_z[0] = PAT_Z; data_z[1] = ONES; valid_z = 2'b01;
      #1;
      frame("z1", 0, PAT_Z, 0, 16'd1, 1'b1);
      valid_z = 2'b01;
      frame("z2", 0, PAT_Z, 1, 16'd2, 1'b1);

      // counter wrap from a preloaded value
      repeat (2) @(negedge clk);
      force dut_z.frame_cnt = 16'hFFFE;
      @(negedge clk);
      release dut_z.frame_cnt;
      #1;
      chk("wrap_pre", W'(cnt_z), W'(16'hFFFE));
      valid_z = 2'b10;
      frame("wrap1", 1, ONES, -1, 16'hFFFF, 1'b1);
      valid_z = 2'b01;
      frame("wrap2", 0, PAT_Z, -1, 16'h0000, 1'b1);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
